// File: rtl/seq_detect_pkg.sv
// Shared types and constants for the serial pattern detector: FSM state
// encoding and the overlap-mode names used by the controller and match core.
package seq_detect_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_SHIFT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic MODE_NONOVL = 1'b0;
    localparam logic MODE_OVL    = 1'b1;

    // True when a counter of the given value has no headroom left.
    function automatic logic is_all_ones(input logic [31:0] value, input int width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
        return (value & mask) == mask;
    endfunction

endpackage

// File: rtl/pat_match_core.sv
// Bit-serial pattern matcher: keeps the last PAT_W-1 bits and a fill count,
// and flags a match when the incoming bit completes the pattern.
module pat_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             bit_valid,
    input  logic             bit_in,
    input  logic [PAT_W-1:0] pattern,
    input  logic             overlap,
    output logic             match
);

    localparam int FILL_W = (PAT_W > 2) ? $clog2(PAT_W) : 1;
    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W - 1);

    logic [PAT_W-2:0]  hist_q, hist_d;
    logic [FILL_W-1:0] fill_q, fill_d;
    logic [PAT_W-1:0]  window;

    assign window = {hist_q, bit_in};
    assign match  = bit_valid && (window == pattern) && (fill_q == FILL_FULL);

    always_comb begin
        hist_d = hist_q;
        fill_d = fill_q;
        if (clear) begin
            hist_d = '0;
            fill_d = '0;
        end else if (bit_valid) begin
            hist_d = window[PAT_W-2:0];
            // Non-overlapping: forget the bits that formed this match.
            if (match && (overlap == MODE_NONOVL)) begin
                fill_d = '0;
            end else if (fill_q != FILL_FULL) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hist_q <= '0;
            fill_q <= '0;
        end else begin
            hist_q <= hist_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Frame controller: accepts bytes, serializes them MSB-first into the match
// core, counts matches over a frame and pulses done with the final count.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter int PAT_W  = 5,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [PAT_W-1:0]  cfg_pattern,
    input  logic              cfg_overlap,
    input  logic [CNT_W-1:0]  cfg_frame_len,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              busy,
    output logic              hit,
    output logic [CNT_W-1:0]  match_count,
    output logic              overflow,
    output logic              done
);

    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  byte_q, byte_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;
    logic [CNT_W-1:0]   bytes_left_q, bytes_left_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               overflow_q, overflow_d;
    logic [PAT_W-1:0]   pattern_q, pattern_d;
    logic               overlap_q, overlap_d;

    logic core_clear;
    logic core_valid;
    logic core_bit;
    logic core_match;

    assign core_clear = (state_q == ST_IDLE) && start;
    assign core_valid = (state_q == ST_SHIFT);
    assign core_bit   = byte_q[bit_idx_q];

    pat_match_core #(
        .PAT_W (PAT_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .clear     (core_clear),
        .bit_valid (core_valid),
        .bit_in    (core_bit),
        .pattern   (pattern_q),
        .overlap   (overlap_q),
        .match     (core_match)
    );

    always_comb begin
        state_d      = state_q;
        byte_d       = byte_q;
        bit_idx_d    = bit_idx_q;
        bytes_left_d = bytes_left_q;
        count_d      = count_q;
        overflow_d   = overflow_q;
        pattern_d    = pattern_q;
        overlap_d    = overlap_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    pattern_d    = cfg_pattern;
                    overlap_d    = cfg_overlap;
                    bytes_left_d = cfg_frame_len;
                    count_d      = '0;
                    overflow_d   = 1'b0;
                    state_d      = (cfg_frame_len == '0) ? ST_DONE : ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (in_valid) begin
                    byte_d    = in_data;
                    bit_idx_d = IDX_W'(DATA_W - 1);
                    state_d   = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                bit_idx_d = bit_idx_q - 1'b1;
                if (core_match) begin
                    if (is_all_ones(32'(count_q), CNT_W)) begin
                        overflow_d = 1'b1;
                    end else begin
                        count_d = count_q + 1'b1;
                    end
                end
                if (bit_idx_q == '0) begin
                    bytes_left_d = bytes_left_q - 1'b1;
                    state_d      = (bytes_left_q == CNT_W'(1)) ? ST_DONE : ST_LOAD;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            byte_q       <= '0;
            bit_idx_q    <= '0;
            bytes_left_q <= '0;
            count_q      <= '0;
            overflow_q   <= 1'b0;
            pattern_q    <= '0;
            overlap_q    <= MODE_NONOVL;
        end else begin
            state_q      <= state_d;
            byte_q       <= byte_d;
            bit_idx_q    <= bit_idx_d;
            bytes_left_q <= bytes_left_d;
            count_q      <= count_d;
            overflow_q   <= overflow_d;
            pattern_q    <= pattern_d;
            overlap_q    <= overlap_d;
        end
    end

    // Status outputs decode straight from state so reset clears them at once.
    assign in_ready    = (state_q == ST_LOAD);
    assign busy        = (state_q != ST_IDLE);
    assign done        = (state_q == ST_DONE);
    assign hit         = (state_q == ST_SHIFT) && core_match;
    assign match_count = count_q;
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Self-checking bench for seq_detect_ctrl: directed and random frames checked
// against a sliding-window match model built from the byte stream.
module tb_seq_detect_ctrl;

    localparam int PAT_W  = 5;
    localparam int DATA_W = 8;
    localparam int CNT_W  = 8;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clk = 1'b0;
    logic              rst;
    logic              start;
    logic [PAT_W-1:0]  cfg_pattern;
    logic              cfg_overlap;
    logic [CNT_W-1:0]  cfg_frame_len;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic              busy;
    logic              hit;
    logic [CNT_W-1:0]  match_count;
    logic              overflow;
    logic              done;

    int n_tests = 0;
    int n_fail  = 0;

    logic [DATA_W-1:0] fb[$];
    int                gap[$];
    logic [PAT_W-1:0]  pat;
    bit                ovl;
    int                last_total;

    seq_detect_ctrl #(
        .PAT_W  (PAT_W),
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .cfg_pattern   (cfg_pattern),
        .cfg_overlap   (cfg_overlap),
        .cfg_frame_len (cfg_frame_len),
        .in_valid      (in_valid),
        .in_data       (in_data),
        .in_ready      (in_ready),
        .busy          (busy),
        .hit           (hit),
        .match_count   (match_count),
        .overflow      (overflow),
        .done          (done)
    );

    always #5 clk = ~clk;

    // Runs one frame from fb/gap/pat/ovl. Must be entered at a negedge in IDLE;
    // returns at a negedge in IDLE.
    task automatic run_frame(input string name);
        bit bits[$];
        bit eh[$];
        int total;
        int last;
        int k;
        int exp_cnt;
        bit exp_ovf;
        total = 0;
        last  = -1000;
        k     = 0;
        foreach (fb[i]) begin
            for (int b = DATA_W - 1; b >= 0; b--) bits.push_back(fb[i][b]);
        end
        for (int p = 0; p < bits.size(); p++) begin
            bit h;
            int w;
            h = 0;
            if (p >= PAT_W - 1) begin
                w = 0;
                for (int j = p - PAT_W + 1; j <= p; j++) w = w * 2 + int'(bits[j]);
                if (w == int'(pat) && (ovl || (p - last) >= PAT_W)) begin
                    h = 1;
                    last = p;
                    total++;
                end
            end
            eh.push_back(h);
        end
        exp_cnt = (total > CNT_MAX) ? CNT_MAX : total;
        exp_ovf = (total > CNT_MAX);
        last_total = total;

        start         = 1'b1;
        cfg_pattern   = pat;
        cfg_overlap   = ovl;
        cfg_frame_len = CNT_W'(fb.size());
        @(negedge clk);
        start = 1'b0;
        foreach (fb[i]) begin
            for (int g = 0; g < gap[i]; g++) begin
                in_valid      = 1'b0;
                start         = 1'($urandom);
                cfg_pattern   = PAT_W'($urandom);
                cfg_overlap   = 1'($urandom);
                cfg_frame_len = CNT_W'($urandom);
                n_tests++;
                if ({in_ready, busy, done, hit} !== 4'b1100) begin
                    $display("FAIL %s gap ctrl {rdy,busy,done,hit} got %b want 1100", name, {in_ready, busy, done, hit});
                    n_fail++;
                end
                @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = fb[i];
            n_tests++;
            if ({in_ready, busy, done} !== 3'b110) begin
                $display("FAIL %s accept ctrl {rdy,busy,done} got %b want 110", name, {in_ready, busy, done});
                n_fail++;
            end
            @(negedge clk);
            for (int b = 0; b < DATA_W; b++) begin
                in_valid = 1'($urandom);
                in_data  = DATA_W'($urandom);
                n_tests++;
                if ({in_ready, busy, done} !== 3'b010) begin
                    $display("FAIL %s shift ctrl {rdy,busy,done} got %b want 010", name, {in_ready, busy, done});
                    n_fail++;
                end
                n_tests++;
                if (hit !== eh[k]) begin
                    $display("FAIL %s hit bit %0d got %b want %b", name, k, hit, eh[k]);
                    n_fail++;
                end
                k++;
                @(negedge clk);
            end
            in_valid = 1'b0;
        end
        start         = 1'($urandom);
        cfg_pattern   = PAT_W'($urandom);
        cfg_overlap   = 1'($urandom);
        cfg_frame_len = CNT_W'($urandom);
        n_tests++;
        if ({in_ready, busy, done} !== 3'b011) begin
            $display("FAIL %s done ctrl {rdy,busy,done} got %b want 011", name, {in_ready, busy, done});
            n_fail++;
        end
        n_tests++;
        if (match_count !== CNT_W'(exp_cnt) || overflow !== exp_ovf) begin
            $display("FAIL %s count/ovf got %0d/%b want %0d/%b", name, match_count, overflow, exp_cnt, exp_ovf);
            n_fail++;
        end
        @(negedge clk);
        start = 1'b0;
        n_tests++;
        if ({in_ready, busy, done} !== 3'b000 || match_count !== CNT_W'(exp_cnt)) begin
            $display("FAIL %s idle ctrl/count got %b/%0d want 000/%0d", name, {in_ready, busy, done}, match_count, exp_cnt);
            n_fail++;
        end
        $display("[TB] frame %s: %0d bytes, pattern %b, overlap %0d, matches %0d", name, fb.size(), pat, ovl, total);
    endtask

    task automatic test_reset;
        rst = 1'b0;
        start = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0; cfg_frame_len = '0;
        in_valid = 1'b0; in_data = '0;
        #1;
        n_tests++;
        if ({in_ready, busy, hit, done, overflow} !== 5'b0 || match_count !== '0) begin
            $display("FAIL reset outputs got %b/%0d want 00000/0", {in_ready, busy, hit, done, overflow}, match_count);
            n_fail++;
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({in_ready, busy, done} !== 3'b000) begin
            $display("FAIL reset idle got %b want 000", {in_ready, busy, done});
            n_fail++;
        end
    endtask

    task automatic test_overlap;
        fb = '{8'hDB}; gap = '{0}; pat = 5'b11011; ovl = 1'b1;
        run_frame("overlap_db");
        n_tests++;
        if (last_total != 2) begin
            $display("FAIL overlap_db model total got %0d want 2", last_total);
            n_fail++;
        end
    endtask

    task automatic test_nonoverlap;
        fb = '{8'hDB}; gap = '{0}; pat = 5'b11011; ovl = 1'b0;
        run_frame("nonoverlap_db");
    endtask

    task automatic test_gap_boundary;
        fb = '{8'h03, 8'h60}; gap = '{0, 10}; pat = 5'b11011; ovl = 1'b1;
        run_frame("gap_boundary");
    endtask

    task automatic test_zero_len;
        fb.delete(); gap.delete(); pat = 5'b10101; ovl = 1'b0;
        run_frame("zero_len");
    endtask

    task automatic test_saturate;
        fb.delete(); gap.delete();
        for (int i = 0; i < 40; i++) begin
            fb.push_back(8'h00);
            gap.push_back(0);
        end
        pat = 5'b00000; ovl = 1'b1;
        run_frame("saturate");
    endtask

    task automatic test_random;
        for (int f = 0; f < 25; f++) begin
            int n;
            n = $urandom_range(1, 6);
            fb.delete(); gap.delete();
            for (int i = 0; i < n; i++) begin
                if (f % 3 == 0) fb.push_back((($urandom % 2) == 0) ? 8'hDB : 8'h6D);
                else fb.push_back(DATA_W'($urandom));
                gap.push_back($urandom_range(0, 3));
            end
            pat = (f % 3 == 0) ? 5'b11011 : PAT_W'($urandom);
            ovl = 1'($urandom);
            run_frame($sformatf("random%0d", f));
        end
    endtask

    task automatic test_back_to_back;
        fb = '{8'hB6, 8'hDB}; gap = '{0, 0}; pat = 5'b10110; ovl = 1'b0;
        run_frame("b2b_a");
        fb = '{8'h6D}; gap = '{0}; pat = 5'b01101; ovl = 1'b1;
        run_frame("b2b_b");
    endtask

    task automatic test_abort;
        start = 1'b1; cfg_pattern = 5'b00000; cfg_overlap = 1'b1; cfg_frame_len = 8'd3;
        @(negedge clk);
        start = 1'b0; in_valid = 1'b1; in_data = 8'h00;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(negedge clk);
        n_tests++;
        if (match_count !== 8'd2) begin
            $display("FAIL abort pre-count got %0d want 2", match_count);
            n_fail++;
        end
        #2 rst = 1'b0;
        #1;
        n_tests++;
        if ({in_ready, busy, hit, done, overflow} !== 5'b0 || match_count !== '0) begin
            $display("FAIL abort async clear got %b/%0d want 00000/0", {in_ready, busy, hit, done, overflow}, match_count);
            n_fail++;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            n_tests++;
            if ({busy, done} !== 2'b00) begin
                $display("FAIL abort hold cycle %0d {busy,done} got %b want 00", c, {busy, done});
                n_fail++;
            end
        end
        rst = 1'b1;
        @(negedge clk);
        $display("[TB] abort: reset mid-shift cleared outputs");
        fb = '{8'h1B}; gap = '{2}; pat = 5'b11011; ovl = 1'b1;
        run_frame("after_abort");
    endtask

    initial begin
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_gap_boundary();
        test_zero_len();
        test_saturate();
        test_zero_len();
        test_back_to_back();
        test_random();
        test_abort();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
